// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed N-digit seven-segment display driver.
// Latches a packed hex/BCD value into a pending bank, promotes it to the
// active bank at each frame boundary, decodes one nibble per slot and scans
// the digit enables with a per-slot blank interval against ghosting.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   value      packed nibbles, [3:0] = digit 0 (rightmost)
//   dp_in      decimal-point request per digit
//   blank_lz   suppress leading zeros
//   load       one-cycle strobe capturing value/dp_in/blank_lz
//   seg_out    segments {a,b,c,d,e,f,g}, bit 6 = a
//   dp_out     decimal-point segment
//   dig_out    one-hot digit enable, bit i = digit i
//   frame_done pulse on the last output cycle of each full scan
module seg_scan_driver #(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned PRESCALE       = 1000,
  parameter int unsigned BLANK          = 16,
  parameter int unsigned HEX            = 1,
  parameter int unsigned SEG_ACTIVE_LOW = 0,
  parameter int unsigned DIG_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank_lz,
  input  logic                  load,
  output logic [6:0]            seg_out,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     dig_out,
  output logic                  frame_done
);

  localparam int unsigned VW = 4 * DIGITS;
  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic DIG_INV = (DIG_ACTIVE_LOW != 0);
  localparam logic HEX_EN  = (HEX != 0);

  // Scan position
  logic [CW-1:0] cnt, cnt_nxt;
  logic [IW-1:0] idx, idx_nxt;
  logic          slot_end;
  logic          frame_end;

  // Register banks
  logic [VW-1:0]     pend_val, act_val;
  logic [DIGITS-1:0] pend_dp,  act_dp;
  logic              pend_lz,  act_lz;

  // Decode path
  logic [3:0]        nib;
  logic              dp_sel;
  logic              blank_dig;
  logic              zrun;
  logic [DIGITS-1:0] lz_mask;
  logic              lit;
  logic [6:0]        seg_c;
  logic              dp_c;
  logic [DIGITS-1:0] dig_c;

  // Font lookup, active-high segments {a..g}
  function automatic logic [6:0] font(input logic [3:0] n);
    logic [6:0] f;
    case (n)
      4'h0: f = 7'b1111110;
      4'h1: f = 7'b0110000;
      4'h2: f = 7'b1101101;
      4'h3: f = 7'b1111001;
      4'h4: f = 7'b0110011;
      4'h5: f = 7'b1011011;
      4'h6: f = 7'b1011111;
      4'h7: f = 7'b1110000;
      4'h8: f = 7'b1111111;
      4'h9: f = 7'b1111011;
      4'hA: f = HEX_EN ? 7'b1110111 : 7'b0000000;
      4'hB: f = HEX_EN ? 7'b0011111 : 7'b0000000;
      4'hC: f = HEX_EN ? 7'b1001110 : 7'b0000000;
      4'hD: f = HEX_EN ? 7'b0111101 : 7'b0000000;
      4'hE: f = HEX_EN ? 7'b1001111 : 7'b0000000;
      4'hF: f = HEX_EN ? 7'b1000111 : 7'b0000000;
      default: f = 7'b0000000;
    endcase
    return f;
  endfunction

  // Scan position register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= cnt_nxt;
      idx <= idx_nxt;
    end
  end

  // Next scan position; frame boundary is the wrap out of the last digit slot
  always_comb begin
    slot_end  = (cnt == CNT_LAST);
    frame_end = slot_end && (idx == IDX_LAST);
    cnt_nxt   = slot_end ? '0 : cnt + CW'(1);
    idx_nxt   = idx;
    if (slot_end) begin
      idx_nxt = (idx == IDX_LAST) ? '0 : idx + IW'(1);
    end
  end

  // Pending bank: last load of the frame wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_val <= '0;
      pend_dp  <= '0;
      pend_lz  <= 1'b0;
    end else if (load) begin
      pend_val <= value;
      pend_dp  <= dp_in;
      pend_lz  <= blank_lz;
    end
  end

  // Active bank: promoted only at the frame boundary; a coincident load bypasses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_val <= '0;
      act_dp  <= '0;
      act_lz  <= 1'b0;
    end else if (frame_end) begin
      if (load) begin
        act_val <= value;
        act_dp  <= dp_in;
        act_lz  <= blank_lz;
      end else begin
        act_val <= pend_val;
        act_dp  <= pend_dp;
        act_lz  <= pend_lz;
      end
    end
  end

  // Blank interval at the head of every slot
  if (BLANK == 0) begin : g_noblank
    assign lit = 1'b1;
  end else begin : g_blank
    assign lit = (cnt >= CW'(BLANK));
  end

  // Leading-zero mask (digit i blankable when it and all higher nibbles are 0)
  // and per-slot nibble / dp selection
  always_comb begin
    zrun      = 1'b1;
    lz_mask   = '0;
    nib       = 4'h0;
    dp_sel    = 1'b0;
    blank_dig = 1'b0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      zrun = zrun && (act_val[4*i +: 4] == 4'h0);
      if (i != 0) lz_mask[i] = zrun;
    end
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (idx == IW'(i)) begin
        nib       = act_val[4*i +: 4];
        dp_sel    = act_dp[i];
        blank_dig = act_lz && lz_mask[i];
      end
    end
  end

  // Active-high pin values for the current scan position
  always_comb begin
    seg_c = 7'b0000000;
    dp_c  = 1'b0;
    dig_c = '0;
    if (lit) begin
      dig_c = DIGITS'(1) << idx;
      dp_c  = dp_sel;
      if (!blank_dig) seg_c = font(nib);
    end
  end

  // Output registers; polarity applied here only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_out    <= {7{SEG_INV}};
      dp_out     <= SEG_INV;
      dig_out    <= {DIGITS{DIG_INV}};
      frame_done <= 1'b0;
    end else begin
      seg_out    <= seg_c ^ {7{SEG_INV}};
      dp_out     <= dp_c ^ SEG_INV;
      dig_out    <= dig_c ^ {DIGITS{DIG_INV}};
      frame_done <= frame_end;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver. Two instances share stimulus:
// dut_a uses HEX=1 with default polarities, dut_b uses HEX=0 with inverted
// segment and non-inverted digit polarity. Expected pin values come from a
// frame-arithmetic reference model.
module tb_seg_scan_driver;

  localparam int P     = 8;
  localparam int D     = 4;
  localparam int BL    = 2;
  localparam int FRAME = P * D;

  logic        clk;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic        load;

  logic [6:0] seg_a, seg_b;
  logic       dp_a, dp_b;
  logic [3:0] dig_a, dig_b;
  logic       fd_a, fd_b;

  int n_pass  = 0;
  int n_total = 0;

  seg_scan_driver #(.DIGITS(D), .PRESCALE(P), .BLANK(BL), .HEX(1),
                    .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(1)) dut_a (
    .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .blank_lz(blank_lz),
    .load(load), .seg_out(seg_a), .dp_out(dp_a), .dig_out(dig_a), .frame_done(fd_a));

  seg_scan_driver #(.DIGITS(D), .PRESCALE(P), .BLANK(BL), .HEX(0),
                    .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(0)) dut_b (
    .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .blank_lz(blank_lz),
    .load(load), .seg_out(seg_b), .dp_out(dp_b), .dig_out(dig_b), .frame_done(fd_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] font_ref(input logic [3:0] n, input bit hex);
    if (!hex && n > 4'd9) return 7'b0000000;
    case (n)
      4'h0: return 7'b1111110;  4'h1: return 7'b0110000;
      4'h2: return 7'b1101101;  4'h3: return 7'b1111001;
      4'h4: return 7'b0110011;  4'h5: return 7'b1011011;
      4'h6: return 7'b1011111;  4'h7: return 7'b1110000;
      4'h8: return 7'b1111111;  4'h9: return 7'b1111011;
      4'hA: return 7'b1110111;  4'hB: return 7'b0011111;
      4'hC: return 7'b1001110;  4'hD: return 7'b0111101;
      4'hE: return 7'b1001111;  default: return 7'b1000111;
    endcase
  endfunction

  // Reference model: s counts scan cycles since reset; slot, digit and frame
  // follow by division. e_* describe the pins after the edge that consumed s.
  int          s;
  logic [15:0] m_pv, m_av;
  logic [3:0]  m_pdp, m_adp;
  logic        m_plz, m_alz;
  int          e_c, e_d, e_f;
  logic        e_lit, e_dp, e_fd;
  logic [6:0]  e_seg_h, e_seg_n;
  logic [3:0]  e_dig;
  logic [3:0]  m_nib;
  logic        m_blanked;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s = 0;
      m_pv = 16'h0; m_pdp = 4'h0; m_plz = 1'b0;
      m_av = 16'h0; m_adp = 4'h0; m_alz = 1'b0;
      e_c = 0; e_d = 0; e_f = -1; e_lit = 1'b0;
      e_seg_h = 7'h0; e_seg_n = 7'h0; e_dp = 1'b0; e_dig = 4'h0; e_fd = 1'b0;
    end else begin
      e_c   = s % P;
      e_d   = (s / P) % D;
      e_f   = s / FRAME;
      e_lit = (e_c >= BL);
      m_nib = 4'(m_av >> (4 * e_d));
      m_blanked = m_alz && (e_d > 0) && ((m_av >> (4 * e_d)) == 16'h0);
      e_seg_h = (e_lit && !m_blanked) ? font_ref(m_nib, 1'b1) : 7'h0;
      e_seg_n = (e_lit && !m_blanked) ? font_ref(m_nib, 1'b0) : 7'h0;
      e_dp  = e_lit && m_adp[e_d];
      e_dig = e_lit ? 4'(1 << e_d) : 4'h0;
      e_fd  = (e_c == P - 1) && (e_d == D - 1);
      if (load) begin
        m_pv = value; m_pdp = dp_in; m_plz = blank_lz;
      end
      if (e_fd) begin
        m_av = m_pv; m_adp = m_pdp; m_alz = m_plz;
      end
      s++;
    end
  end

  logic [12:0] got_a, got_b, exp_a, exp_b;
  assign got_a = {seg_a, dp_a, dig_a, fd_a};
  assign got_b = {seg_b, dp_b, dig_b, fd_b};
  assign exp_a = {e_seg_h, e_dp, ~e_dig, e_fd};
  assign exp_b = {~e_seg_n, ~e_dp, e_dig, e_fd};

  localparam logic [12:0] RST_A = {7'b0000000, 1'b0, 4'b1111, 1'b0};
  localparam logic [12:0] RST_B = {7'b1111111, 1'b1, 4'b0000, 1'b0};

  task automatic test_reset();
    rst = 1'b0; load = 1'b0; value = 16'h0; dp_in = 4'h0; blank_lz = 1'b0;
    #3 rst = 1'b1;
    #1;
    n_total++;
    if (got_a !== RST_A || got_b !== RST_B)
      $display("FAIL reset_async a=%h exp %h b=%h exp %h", got_a, RST_A, got_b, RST_B);
    else n_pass++;
    repeat (2) @(negedge clk);
    n_total++;
    if (got_a !== RST_A || got_b !== RST_B)
      $display("FAIL reset_held a=%h exp %h b=%h exp %h", got_a, RST_A, got_b, RST_B);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_idle();
    int pulses = 0;
    for (int k = 1; k <= 2 * FRAME; k++) begin
      @(negedge clk);
      n_total++;
      if (got_a !== exp_a || got_b !== exp_b)
        $display("FAIL idle_model k=%0d a=%h exp %h b=%h exp %h", k, got_a, exp_a, got_b, exp_b);
      else n_pass++;
      if (fd_a) pulses++;
      if (k == BL) begin
        n_total++;
        if (dig_a !== 4'b1111) $display("FAIL idle_blank_head dig=%b exp 1111", dig_a);
        else n_pass++;
      end
      if (k == BL + 1) begin
        n_total++;
        if (dig_a !== 4'b1110) $display("FAIL idle_first_lit dig=%b exp 1110", dig_a);
        else n_pass++;
      end
      if (e_lit) begin
        n_total++;
        if (seg_a !== 7'b1111110) $display("FAIL idle_zero_font seg=%b exp 1111110", seg_a);
        else n_pass++;
      end
    end
    n_total++;
    if (pulses != 2) $display("FAIL idle_frame_pulses got %0d exp 2", pulses);
    else n_pass++;
  endtask

  task automatic test_hex();
    logic [6:0] tbl [4];
    int  target;
    bit  done = 1'b0;
    tbl = '{7'b1000111, 7'b1011011, 7'b1110111, 7'b1101101};
    value = 16'h2A5F; dp_in = 4'h0; blank_lz = 1'b0; load = 1'b1;
    target = s / FRAME + 1;
    for (int k = 0; k < 3 * FRAME && !done; k++) begin
      @(negedge clk);
      load = 1'b0;
      n_total++;
      if (got_a !== exp_a || got_b !== exp_b)
        $display("FAIL hex_model a=%h exp %h b=%h exp %h", got_a, exp_a, got_b, exp_b);
      else n_pass++;
      if (e_f == target && e_lit) begin
        n_total++;
        if (seg_a !== tbl[e_d]) $display("FAIL hex_font d=%0d seg=%b exp %b", e_d, seg_a, tbl[e_d]);
        else n_pass++;
        if (e_d == 0 || e_d == 2) begin
          n_total++;
          if (seg_b !== 7'b1111111) $display("FAIL nohex_blank d=%0d seg=%b exp 1111111", e_d, seg_b);
          else n_pass++;
        end
      end
      if (e_f == target + 1) done = 1'b1;
    end
    if (!done) begin
      n_total++;
      $display("FAIL hex_timeout frame=%0d exp %0d", e_f, target + 1);
    end
  endtask

  task automatic test_lz();
    logic [6:0] tbl [4];
    logic [6:0] want;
    int  target;
    bit  second = 1'b0;
    bit  done = 1'b0;
    tbl = '{7'b1111110, 7'b0110011, 7'b0000000, 7'b0000000};
    value = 16'h0040; dp_in = 4'h0; blank_lz = 1'b1; load = 1'b1;
    target = s / FRAME + 1;
    for (int k = 0; k < 4 * FRAME && !done; k++) begin
      @(negedge clk);
      load = 1'b0;
      n_total++;
      if (got_a !== exp_a || got_b !== exp_b)
        $display("FAIL lz_model a=%h exp %h b=%h exp %h", got_a, exp_a, got_b, exp_b);
      else n_pass++;
      if (e_f == target && !second) begin
        value = 16'h0000; load = 1'b1; second = 1'b1;
      end
      if (e_lit && (e_f == target || e_f == target + 1)) begin
        want = (e_f == target) ? tbl[e_d] : ((e_d == 0) ? 7'b1111110 : 7'b0000000);
        n_total++;
        if (seg_a !== want) $display("FAIL lz_font f=%0d d=%0d seg=%b exp %b", e_f - target, e_d, seg_a, want);
        else n_pass++;
      end
      if (e_f == target + 2) done = 1'b1;
    end
    if (!done) begin
      n_total++;
      $display("FAIL lz_timeout frame=%0d exp %0d", e_f, target + 2);
    end
  endtask

  task automatic test_midframe();
    logic [6:0] want;
    int  target;
    bit  mid_sent = 1'b0;
    bit  edge_sent = 1'b0;
    bit  done = 1'b0;
    value = 16'h8888; dp_in = 4'h0; blank_lz = 1'b0; load = 1'b1;
    target = s / FRAME + 1;
    for (int k = 0; k < 5 * FRAME && !done; k++) begin
      @(negedge clk);
      load = 1'b0;
      n_total++;
      if (got_a !== exp_a || got_b !== exp_b)
        $display("FAIL mid_model a=%h exp %h b=%h exp %h", got_a, exp_a, got_b, exp_b);
      else n_pass++;
      if (e_lit && e_f >= target && e_f <= target + 2) begin
        want = (e_f == target) ? 7'b1111111 : (e_f == target + 1) ? 7'b0110000 : 7'b1111001;
        n_total++;
        if (seg_a !== want) $display("FAIL mid_font f=%0d d=%0d seg=%b exp %b", e_f - target, e_d, seg_a, want);
        else n_pass++;
      end
      if (!mid_sent && e_f == target && e_d == 1 && e_c == 0) begin
        value = 16'h1111; load = 1'b1; mid_sent = 1'b1;
      end else if (!edge_sent && s / FRAME == target + 1 && s % FRAME == FRAME - 1) begin
        value = 16'h3333; load = 1'b1; edge_sent = 1'b1;
      end
      if (e_f == target + 3) done = 1'b1;
    end
    if (!done || !edge_sent) begin
      n_total++;
      $display("FAIL mid_timeout frame=%0d exp %0d", e_f, target + 3);
    end
  endtask

  task automatic test_dp();
    logic [6:0] tbl [4];
    logic [6:0] want_seg;
    logic       want_dp;
    int  target;
    bit  done = 1'b0;
    tbl = '{7'b0110011, 7'b1111001, 7'b1101101, 7'b0110000};
    value = 16'h1234; dp_in = 4'b0100; blank_lz = 1'b0; load = 1'b1;
    target = s / FRAME + 1;
    for (int k = 0; k < 3 * FRAME && !done; k++) begin
      @(negedge clk);
      load = 1'b0;
      n_total++;
      if (got_a !== exp_a || got_b !== exp_b)
        $display("FAIL dp_model a=%h exp %h b=%h exp %h", got_a, exp_a, got_b, exp_b);
      else n_pass++;
      if (e_f == target) begin
        want_dp  = !(e_lit && e_d == 2);
        want_seg = e_lit ? ~tbl[e_d] : 7'b1111111;
        n_total++;
        if (dp_b !== want_dp || seg_b !== want_seg)
          $display("FAIL dp_lowpol c=%0d d=%0d dp=%b seg=%b exp dp=%b seg=%b",
                   e_c, e_d, dp_b, seg_b, want_dp, want_seg);
        else n_pass++;
      end
      if (e_f == target + 1) done = 1'b1;
    end
    if (!done) begin
      n_total++;
      $display("FAIL dp_timeout frame=%0d exp %0d", e_f, target + 1);
    end
  endtask

  task automatic test_random();
    logic [31:0] v;
    for (int k = 0; k < 6 * FRAME; k++) begin
      load = ($urandom_range(0, 5) == 0);
      v = $urandom;
      case ($urandom_range(0, 3))
        0: v = v & 32'h0000_000F;
        1: v = v & 32'h0000_00FF;
        2: v = v & 32'h0000_0F0F;
        default: ;
      endcase
      value    = 16'(v);
      dp_in    = 4'($urandom);
      blank_lz = 1'($urandom);
      @(negedge clk);
      load = 1'b0;
      n_total++;
      if (got_a !== exp_a || got_b !== exp_b)
        $display("FAIL rand_model k=%0d a=%h exp %h b=%h exp %h", k, got_a, exp_a, got_b, exp_b);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    value = 16'h9876; dp_in = 4'hF; blank_lz = 1'b0; load = 1'b1;
    for (int k = 0; k < 3 * FRAME && !found; k++) begin
      @(negedge clk);
      load = 1'b0;
      if (e_d == 2 && e_c == 4) found = 1'b1;
    end
    n_total++;
    if (!found) $display("FAIL rstmid_timeout d=%0d c=%0d exp d=2 c=4", e_d, e_c);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++;
    if (got_a !== RST_A || got_b !== RST_B)
      $display("FAIL rstmid_async a=%h exp %h b=%h exp %h", got_a, RST_A, got_b, RST_B);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= FRAME + 4; k++) begin
      @(negedge clk);
      n_total++;
      if (got_a !== exp_a || got_b !== exp_b)
        $display("FAIL rstmid_model k=%0d a=%h exp %h b=%h exp %h", k, got_a, exp_a, got_b, exp_b);
      else n_pass++;
      if (k == BL + 1) begin
        n_total++;
        if (dig_a !== 4'b1110) $display("FAIL rstmid_restart dig=%b exp 1110", dig_a);
        else n_pass++;
      end
      if (e_lit) begin
        n_total++;
        if (seg_a !== 7'b1111110 || dp_a !== 1'b0)
          $display("FAIL rstmid_zero seg=%b dp=%b exp 1111110 0", seg_a, dp_a);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_hex();
    test_lz();
    test_midframe();
    test_dp();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Time-multiplexed N-digit seven-segment display driver: latches a packed BCD/hex value, decodes each nibble to segments, and scans the digits one at a time with a programmable per-digit dwell and anti-ghosting blank interval. It is the parametrised successor of the team's single-digit combinational segment font. It sits between the numeric datapath and the board's segment/digit-enable pins.

## Interface
- DIGITS, 4: number of digits scanned; legal 1..8.
- PRESCALE, 1000: clocks per digit slot; legal ≥2.
- BLANK, 16: leading cycles of each slot with all digits off; legal 0..PRESCALE-1.
- HEX, 1: 1 = nibbles 10-15 shown as A b C d E F; 0 = shown as all segments off.
- SEG_ACTIVE_LOW, 0: 1 inverts seg_out and dp_out at the pins.
- DIG_ACTIVE_LOW, 1: 1 inverts dig_out at the pins.
- clk  in  1  system clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- value  in  4*DIGITS  packed nibbles; [3:0] = digit 0 (least significant, rightmost).
- dp_in  in  DIGITS  decimal-point request per digit.
- blank_lz  in  1  1 = suppress leading zeros.
- load  in  1  one-cycle strobe capturing value/dp_in/blank_lz into the pending register.
- seg_out  out  7  segments {a,b,c,d,e,f,g}; bit 6 = a, bit 0 = g.
- dp_out  out  1  decimal-point segment.
- dig_out  out  DIGITS  one-hot digit enable; bit i = digit i.
- frame_done  out  1  one-cycle pulse at the last cycle of each full scan.

## Operation
- Font (active-high, before polarity): 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
- Two register banks: pending (written on load) and active (drives display). Pending copies into active at each frame boundary (wrap into digit 0 slot), so a frame never shows mixed values.
- load in the same cycle as a frame boundary: the new input goes straight into active (bypass) and into pending.
- Scan state: slot counter cnt 0..PRESCALE-1, digit index idx 0..DIGITS-1. cnt wraps to 0 → idx increments; idx wraps DIGITS-1 → 0 (frame boundary).
- Within a slot: cnt < BLANK → all digits inactive, seg_out and dp_out inactive. cnt ≥ BLANK → dig_out bit idx active, seg_out = font(active nibble idx), dp_out = active dp[idx].
- Leading-zero blanking (active blank_lz = 1): digit i > 0 shows segments off when it and every more-significant nibble are 0. Digit 0 is never blanked. dp_out is unaffected by blanking.
- Polarity parameters apply only at the output registers.

## Timing
- All outputs are registered and reflect the cnt/idx state of the previous cycle. The external slot is exactly PRESCALE cycles; the frame is DIGITS*PRESCALE cycles.
- Reset (asynchronous, any time, including mid-slot): cnt = 0, idx = 0, pending and active = 0 with blank_lz = 0, frame_done = 0. seg_out, dp_out and dig_out are at their inactive levels (for the defaults: seg_out = 0000000, dp_out = 0, dig_out = all ones).
- After reset release, digit 0 is first enabled on the clock edge BLANK+1 and shows "0".
- frame_done is high in the same cycle the last cycle of digit DIGITS-1 is output, and low otherwise.
- load → visible: appears at the first digit-0 lit cycle after the next frame boundary. Worst-case latency is DIGITS*PRESCALE+BLANK+1 cycles.
- Multiple loads within one frame: the last one wins.

## Test plan
- Reset then idle, DIGITS=4, PRESCALE=8, BLANK=2: dig_out cycles 1110→1101→1011→0111 (each active 6 of 8 cycles, all ones for 2), seg_out = 1111110 whenever a digit is lit, frame_done pulses every 32 cycles.
- load value=16'h2A5F with HEX=1: the next frame shows digit 0..3 as 1000111, 1011011, 1110111, 1101101. The same value with HEX=0 shows digits 0 and 2 as 0000000.
- blank_lz=1 with value=16'h0040: digits 3 and 2 show 0000000, digit 1 shows 0110011, digit 0 shows 1111110. With value=16'h0000, only digit 0 is lit as "0".
- Issue load of 16'h1111 mid-frame while 16'h8888 is displayed: the remaining digits of the current frame still show 8. Then load at exactly the frame-boundary cycle: the new value shows from digit 0 of that frame.
- dp_in=4'b0100 with SEG_ACTIVE_LOW=1: dp_out is low only during the lit cycles of digit 2, and seg_out is the bitwise inverse of the font.
- Assert rst mid-slot on digit 2: all outputs go inactive immediately without waiting for a clock edge. After release, the scan restarts at digit 0 and shows 0000.
